// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: instruction ROM request/response, decode
// hazard and redirect inputs, and the IF/ID pipeline register outputs.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_pc4;
  logic              halted;

  // Fetch-unit side: requests instructions and produces IF/ID.
  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output if_id_pc4,
    output halted
  );

  // System side: ROM, decode stage and branch resolution.
  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_pc4,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the returned word into IF/ID. A fetched halt word is held as
// speculative for HALT_DRAIN unstalled cycles; any redirect inside that
// window cancels it, otherwise fetch stops for good until reset.
module fetch_unit #(
  parameter int unsigned ADDR_W     = 5,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned HALT_DRAIN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_HALT_WAIT = 2'd1;
  localparam logic [1:0] S_HALTED    = 2'd2;

  // Drain counter is 4 bits wide, enough for a window of up to 15 cycles.
  localparam logic [3:0] DRAIN_LIMIT = 4'(HALT_DRAIN);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_tgt_s;
  logic [3:0]  cnt_inc_s;
  logic        redirect_lsb_unused_s;

  assign pc_plus4_s     = pc_q + 32'd4;
  assign redirect_tgt_s = {bus.redirect_pc[31:2], 2'b00};
  assign cnt_inc_s      = cnt_q + 4'd1;
  // Byte-offset bits of the target are discarded by design.
  assign redirect_lsb_unused_s = ^bus.redirect_pc[1:0];

  // ROM word address comes straight from the PC so the returned word is
  // available within the same cycle.
  assign bus.imem_addr   = pc_q[ADDR_W+1:2];
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_pc4   = ifpc4_q;
  assign bus.halted      = halted_q;

  // Next-state logic: redirect beats stall beats advance, except in HALTED.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    ifpc4_d  = ifpc4_q;
    halted_d = halted_q;
    case (state_q)
      S_RUN: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_tgt_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else if (bus.stall) begin
          state_d = S_RUN;
        end else begin
          valid_d = 1'b1;
          instr_d = bus.imem_instr;
          ifpc_d  = pc_q;
          ifpc4_d = pc_plus4_s;
          if (bus.imem_instr == HALT_INSTR) begin
            // PC parks on the halt word so a cancelled halt can be refetched.
            state_d = S_HALT_WAIT;
            cnt_d   = 4'd0;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end
      S_HALT_WAIT: begin
        if (bus.redirect_valid) begin
          // Halt was on a wrong path: cancel it and resume at the target.
          pc_d    = redirect_tgt_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else if (bus.stall) begin
          state_d = S_HALT_WAIT;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          cnt_d   = cnt_inc_s;
          if (cnt_inc_s == DRAIN_LIMIT) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = S_HALT_WAIT;
          end
        end
      end
      S_HALTED: begin
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
        halted_d = 1'b1;
        state_d  = S_HALTED;
      end
      default: begin
        // Unreachable encoding: recover to a clean RUN with a bubble.
        state_d  = S_RUN;
        cnt_d    = 4'd0;
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
        halted_d = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID register update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      pc_q     <= 32'd0;
      cnt_q    <= 4'd0;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      ifpc_q   <= 32'd0;
      ifpc4_q  <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      ifpc4_q  <= ifpc4_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID entries are queued as
// stimulus is driven and popped whenever a new valid instruction appears.
module tb_fetch_unit;
  localparam int unsigned ADDR_W     = 5;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned HALT_DRAIN = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom [0:31];
  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus();

  fetch_unit #(
    .ADDR_W(ADDR_W),
    .HALT_INSTR(HALT_INSTR),
    .NOP_INSTR(NOP_INSTR),
    .HALT_DRAIN(HALT_DRAIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = rom[bus.imem_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input int w);
    exp_t e;
    e.instr = rom[w];
    e.pc    = 32'(w * 4);
    e.pc4   = 32'(w * 4 + 4);
    sb_q.push_back(e);
  endtask

  task automatic expect_entry(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    sb_q.push_back(e);
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    exp_t e;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    @(negedge clk);
    if (!st && !rv && bus.if_id_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_val("if_id_instr", bus.if_id_instr, e.instr);
        check_val("if_id_pc", bus.if_id_pc, e.pc);
        check_val("if_id_pc4", bus.if_id_pc4, e.pc4);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 32'(k);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    // Reset values.
    @(negedge clk);
    check_val("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check_val("rst_valid", 32'(bus.if_id_valid), 32'd0);
    check_val("rst_instr", bus.if_id_instr, NOP_INSTR);
    check_val("rst_pc", bus.if_id_pc, 32'd0);
    check_val("rst_pc4", bus.if_id_pc4, 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch then a two-cycle stall at pc=8.
    expect_word(0);
    expect_word(1);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'd0);
      check_val("stall_imem_addr", 32'(bus.imem_addr), 32'd2);
      check_val("stall_instr", bus.if_id_instr, 32'd1);
    end
    for (int w = 2; w < 6; w++) begin
      expect_word(w);
      step(1'b0, 1'b0, 32'd0);
    end

    // Redirect with simultaneous stall: redirect wins, low bits dropped.
    step(1'b1, 1'b1, 32'h0000_0031);
    check_val("redir_imem_addr", 32'(bus.imem_addr), 32'd12);
    check_val("redir_valid", 32'(bus.if_id_valid), 32'd0);
    check_val("redir_instr", bus.if_id_instr, NOP_INSTR);
    check_val("redir_pc_hold", bus.if_id_pc, 32'd20);
    expect_word(12);
    step(1'b0, 1'b0, 32'd0);

    // Wrong-path halt cancelled by a redirect two cycles after it lands.
    rom[3] = HALT_INSTR;
    step(1'b0, 1'b1, 32'd8);
    expect_word(2);
    step(1'b0, 1'b0, 32'd0);
    expect_entry(HALT_INSTR, 32'd12);
    step(1'b0, 1'b0, 32'd0);
    check_val("wp_pc_hold", 32'(bus.imem_addr), 32'd3);
    step(1'b0, 1'b0, 32'd0);
    check_val("wp_bubble", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b1, 32'h0000_0010);
    check_val("wp_halted", 32'(bus.halted), 32'd0);
    check_val("wp_imem_addr", 32'(bus.imem_addr), 32'd4);
    for (int w = 4; w < 8; w++) begin
      expect_word(w);
      step(1'b0, 1'b0, 32'd0);
    end
    check_val("wp_halted_later", 32'(bus.halted), 32'd0);

    // Real halt with one stall cycle inside the drain window.
    step(1'b0, 1'b1, 32'd8);
    expect_word(2);
    step(1'b0, 1'b0, 32'd0);
    expect_entry(HALT_INSTR, 32'd12);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check_val("halt_e2", 32'(bus.halted), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_val("halt_e3", 32'(bus.halted), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_val("halt_e4", 32'(bus.halted), 32'd1);
    step(1'b1, 1'b1, 32'h0000_0040);
    check_val("halted_pc_frozen", 32'(bus.imem_addr), 32'd3);
    check_val("halted_sticky", 32'(bus.halted), 32'd1);
    check_val("halted_bubble", 32'(bus.if_id_valid), 32'd0);
    check_val("halted_nop", bus.if_id_instr, NOP_INSTR);

    // Asynchronous reset while HALTED, observed before any clock edge.
    rst_n = 1'b0;
    #1;
    check_val("arst_halted", 32'(bus.halted), 32'd0);
    check_val("arst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check_val("arst_valid", 32'(bus.if_id_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;

    // PC wrap of the ROM word address.
    step(1'b0, 1'b1, 32'h0000_007C);
    check_val("wrap_addr_31", 32'(bus.imem_addr), 32'd31);
    expect_word(31);
    step(1'b0, 1'b0, 32'd0);
    check_val("wrap_imem_addr", 32'(bus.imem_addr), 32'd0);
    expect_entry(32'd0, 32'h0000_0080);
    step(1'b0, 1'b0, 32'd0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
